// File: rtl/branch_ctrl_if.sv
// Decode-stage branch controller bundle.
// Slave side is the controller, master side drives decode operands.
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             flush_i;
    logic             valid_d;
    logic [2:0]       branchcontrol_d;
    logic             link_d;
    logic [31:0]      pc_d;
    logic [15:0]      imm_d;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             rs_rdy;
    logic             rt_rdy;
    logic             cnt_clr;
    logic             stall_o;
    logic             redirect_o;
    logic [31:0]      target_o;
    logic             link_we_o;
    logic [31:0]      link_pc_o;
    logic             in_slot_o;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  stall_i, flush_i, valid_d, branchcontrol_d, link_d,
        input  pc_d, imm_d, rs_val, rt_val, rs_rdy, rt_rdy, cnt_clr,
        output stall_o, redirect_o, target_o, link_we_o, link_pc_o,
        output in_slot_o, br_cnt, taken_cnt, stall_cnt
    );

    modport master (
        output stall_i, flush_i, valid_d, branchcontrol_d, link_d,
        output pc_d, imm_d, rs_val, rt_val, rs_rdy, rt_rdy, cnt_clr,
        input  stall_o, redirect_o, target_o, link_we_o, link_pc_o,
        input  in_slot_o, br_cnt, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// Decode-stage branch resolution: operand stall, condition evaluation,
// registered PC redirect, delay-slot tracking and perf counters.
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SLOT
    } state_t;

    localparam logic [2:0] BR_EQ  = 3'b001;
    localparam logic [2:0] BR_NEQ = 3'b010;
    localparam logic [2:0] BR_GTZ = 3'b011;
    localparam logic [2:0] BR_LEZ = 3'b100;
    localparam logic [2:0] BR_GEZ = 3'b101;
    localparam logic [2:0] BR_LTZ = 3'b110;

    state_t state_q, state_d;

    logic [2:0]  code_q;
    logic [31:0] pc_q;
    logic [15:0] imm_q;
    logic        link_q;

    logic [2:0]  code;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        link;

    logic        is_branch;
    logic        need_rt;
    logic        ready;
    logic        accept;
    logic        taken;
    logic        rs_zero;
    logic        rs_neg;
    logic [31:0] target;

    logic        stall;
    logic        resolve;
    logic        latch;

    logic             redirect_q;
    logic [31:0]      target_q;
    logic             link_we_q;
    logic [31:0]      link_pc_q;
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] stall_q;

    // Operate on the latched branch while waiting, else on live decode.
    always_comb begin
        code = bus.branchcontrol_d;
        pc   = bus.pc_d;
        imm  = bus.imm_d;
        link = bus.link_d;
        if (state_q == WAIT) begin
            code = code_q;
            pc   = pc_q;
            imm  = imm_q;
            link = link_q;
        end
    end

    // Operand readiness and branch acceptance from decode.
    always_comb begin
        is_branch = (bus.branchcontrol_d != 3'b000) &&
                    (bus.branchcontrol_d != 3'b111);
        need_rt   = (code == BR_EQ) || (code == BR_NEQ);
        ready     = bus.rs_rdy & (bus.rt_rdy | ~need_rt);
        accept    = (state_q == IDLE) & bus.valid_d & is_branch &
                    ~bus.stall_i & ~bus.flush_i;
    end

    // Signed branch condition and target address.
    always_comb begin
        rs_zero = (bus.rs_val == 32'd0);
        rs_neg  = bus.rs_val[31];
        taken   = 1'b0;
        case (code)
            BR_EQ:   taken = (bus.rs_val == bus.rt_val);
            BR_NEQ:  taken = (bus.rs_val != bus.rt_val);
            BR_GTZ:  taken = ~rs_neg & ~rs_zero;
            BR_LEZ:  taken = rs_neg | rs_zero;
            BR_GEZ:  taken = ~rs_neg;
            BR_LTZ:  taken = rs_neg;
            default: taken = 1'b0;
        endcase
        target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    end

    // Next-state, stall and resolve decisions; flush overrides all.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        resolve = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ready) begin
                        resolve = 1'b1;
                        state_d = SLOT;
                    end else begin
                        stall   = 1'b1;
                        latch   = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = ~ready;
                if (ready && !bus.stall_i) begin
                    resolve = 1'b1;
                    state_d = SLOT;
                end
            end
            SLOT: begin
                if (bus.valid_d && !bus.stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            stall   = 1'b0;
            resolve = 1'b0;
            latch   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the branch fields when it must wait for operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= 3'b000;
            pc_q   <= 32'd0;
            imm_q  <= 16'd0;
            link_q <= 1'b0;
        end else if (latch) begin
            code_q <= bus.branchcontrol_d;
            pc_q   <= bus.pc_d;
            imm_q  <= bus.imm_d;
            link_q <= bus.link_d;
        end
    end

    // Registered redirect/link pulses and their payloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q <= 1'b0;
            link_we_q  <= 1'b0;
            target_q   <= 32'd0;
            link_pc_q  <= 32'd0;
        end else begin
            redirect_q <= resolve & taken;
            link_we_q  <= resolve & link;
            if (resolve) begin
                target_q  <= target;
                link_pc_q <= pc + 32'd8;
            end
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q    <= '0;
            taken_q <= '0;
            stall_q <= '0;
        end else if (bus.cnt_clr) begin
            br_q    <= '0;
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            if (resolve && (br_q != '1)) begin
                br_q <= br_q + 1'b1;
            end
            if (resolve && taken && (taken_q != '1)) begin
                taken_q <= taken_q + 1'b1;
            end
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.stall_o    = stall;
    assign bus.redirect_o = redirect_q;
    assign bus.target_o   = target_q;
    assign bus.link_we_o  = link_we_q;
    assign bus.link_pc_o  = link_pc_q;
    assign bus.in_slot_o  = (state_q == SLOT);
    assign bus.br_cnt     = br_q;
    assign bus.taken_cnt  = taken_q;
    assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with an expected-result queue
// for each branch resolution.
module tb_branch_ctrl;
    localparam int CNT_W = 6;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        redirect;
        logic [31:0] target;
        logic        link_we;
        logic [31:0] link_pc;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   errs;
    int   exp_br;
    int   exp_tk;
    int   exp_st;
    exp_t sb[$];

    branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic model_taken(input logic [2:0] c,
                                         input logic [31:0] rs,
                                         input logic [31:0] rt);
        logic r;
        r = 1'b0;
        case (c)
            3'd1: r = (rs == rt);
            3'd2: r = (rs != rt);
            3'd3: r = ($signed(rs) > 0);
            3'd4: r = ($signed(rs) <= 0);
            3'd5: r = ($signed(rs) >= 0);
            3'd6: r = ($signed(rs) < 0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.stall_i         = 1'b0;
        bus.flush_i         = 1'b0;
        bus.valid_d         = 1'b0;
        bus.branchcontrol_d = 3'd0;
        bus.link_d          = 1'b0;
        bus.pc_d            = 32'd0;
        bus.imm_d           = 16'd0;
        bus.rs_val          = 32'd0;
        bus.rt_val          = 32'd0;
        bus.rs_rdy          = 1'b1;
        bus.rt_rdy          = 1'b1;
        bus.cnt_clr         = 1'b0;
    endtask

    task automatic drive_br(input logic [2:0] c, input logic lk,
                            input logic [31:0] pc, input logic [15:0] imm,
                            input logic [31:0] rs, input logic [31:0] rt);
        bus.valid_d         = 1'b1;
        bus.branchcontrol_d = c;
        bus.link_d          = lk;
        bus.pc_d            = pc;
        bus.imm_d           = imm;
        bus.rs_val          = rs;
        bus.rt_val          = rt;
    endtask

    task automatic push_exp(input logic [2:0] c, input logic lk,
                            input logic [31:0] pc, input logic [15:0] imm,
                            input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [31:0] off;
        off        = {{16{imm[15]}}, imm};
        e.redirect = model_taken(c, rs, rt);
        e.target   = pc + 32'd4 + (off << 2);
        e.link_we  = lk;
        e.link_pc  = pc + 32'd8;
        sb.push_back(e);
        exp_br = sat(exp_br + 1);
        if (e.redirect) exp_tk = sat(exp_tk + 1);
    endtask

    task automatic check_res(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            errs++;
            $error("FAIL %s: observed no pending entry expected one", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".redirect"}, {31'd0, bus.redirect_o}, {31'd0, e.redirect});
            chk({tag, ".target"}, bus.target_o, e.target);
            chk({tag, ".link_we"}, {31'd0, bus.link_we_o}, {31'd0, e.link_we});
            chk({tag, ".link_pc"}, bus.link_pc_o, e.link_pc);
            chk({tag, ".in_slot"}, {31'd0, bus.in_slot_o}, 32'd1);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".br_cnt"}, 32'(bus.br_cnt), 32'(exp_br));
        chk({tag, ".taken_cnt"}, 32'(bus.taken_cnt), 32'(exp_tk));
        chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_st));
    endtask

    // Delay-slot instruction carrying a branch code with rs not ready:
    // it must be ignored (no stall) and the FSM returns to IDLE.
    task automatic slot_leave(input string tag);
        drive_br(3'd1, 1'b0, 32'h0000_0040, 16'h0001, 32'd0, 32'd0);
        bus.rs_rdy = 1'b0;
        #1;
        chk({tag, ".slot_stall"}, {31'd0, bus.stall_o}, 32'd0);
        step();
        chk({tag, ".slot_exit"}, {31'd0, bus.in_slot_o}, 32'd0);
        chk({tag, ".pulse_drop"}, {31'd0, bus.redirect_o}, 32'd0);
        chk({tag, ".link_drop"}, {31'd0, bus.link_we_o}, 32'd0);
        idle_in();
    endtask

    task automatic quick_br(input string tag, input logic [2:0] c,
                            input logic lk, input logic [31:0] pc,
                            input logic [15:0] imm, input logic [31:0] rs,
                            input logic [31:0] rt);
        drive_br(c, lk, pc, imm, rs, rt);
        #1;
        chk({tag, ".stall"}, {31'd0, bus.stall_o}, 32'd0);
        push_exp(c, lk, pc, imm, rs, rt);
        step();
        check_res(tag);
        slot_leave(tag);
    endtask

    initial begin
        logic [2:0]  codes [4];
        logic [31:0] rsv [3];
        vectors = 0;
        errs    = 0;
        exp_br  = 0;
        exp_tk  = 0;
        exp_st  = 0;
        codes   = '{3'd3, 3'd4, 3'd5, 3'd6};
        rsv     = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
        idle_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.redirect", {31'd0, bus.redirect_o}, 32'd0);
        chk("rst.target", bus.target_o, 32'd0);
        chk("rst.link_we", {31'd0, bus.link_we_o}, 32'd0);
        chk("rst.link_pc", bus.link_pc_o, 32'd0);
        chk("rst.in_slot", {31'd0, bus.in_slot_o}, 32'd0);
        chk_cnt("rst");
        rst = 1'b0;
        step();

        // BEQ resolving immediately
        drive_br(3'd1, 1'b0, 32'h0040_0000, 16'h0004, 32'd5, 32'd5);
        #1;
        chk("beq.stall", {31'd0, bus.stall_o}, 32'd0);
        push_exp(3'd1, 1'b0, 32'h0040_0000, 16'h0004, 32'd5, 32'd5);
        step();
        chk("beq.target_lit", bus.target_o, 32'h0040_0014);
        check_res("beq");
        slot_leave("beq");

        // BNE waiting two cycles on rt, then a held cycle
        drive_br(3'd2, 1'b0, 32'h0040_0100, 16'h0010, 32'd1, 32'd2);
        bus.rt_rdy = 1'b0;
        #1;
        chk("bne.stall0", {31'd0, bus.stall_o}, 32'd1);
        exp_st = sat(exp_st + 1);
        step();
        bus.valid_d         = 1'b0;
        bus.branchcontrol_d = 3'd0;
        bus.pc_d            = 32'hDEAD_BEEF;
        bus.imm_d           = 16'h0000;
        #1;
        chk("bne.stall1", {31'd0, bus.stall_o}, 32'd1);
        exp_st = sat(exp_st + 1);
        step();
        bus.rt_rdy  = 1'b1;
        bus.stall_i = 1'b1;
        #1;
        chk("bne.ready_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        chk("bne.hold_redirect", {31'd0, bus.redirect_o}, 32'd0);
        chk("bne.hold_slot", {31'd0, bus.in_slot_o}, 32'd0);
        bus.stall_i = 1'b0;
        push_exp(3'd2, 1'b0, 32'h0040_0100, 16'h0010, 32'd1, 32'd2);
        step();
        chk("bne.target_lit", bus.target_o, 32'h0040_0144);
        check_res("bne");
        chk("bne.stall_cnt", 32'(bus.stall_cnt), 32'd2);
        slot_leave("bne");

        // BLTZAL taken and not taken
        quick_br("bltzal_t", 3'd6, 1'b1, 32'h0000_1000, 16'hFFFF,
                 32'hFFFF_FFFF, 32'd0);
        quick_br("bltzal_n", 3'd6, 1'b1, 32'h0000_1000, 16'hFFFF,
                 32'h0000_0000, 32'd0);
        chk_cnt("after_link");

        // Clear, then the 12 single-operand signed compares
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        exp_br = 0;
        exp_tk = 0;
        exp_st = 0;
        chk_cnt("clr");
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                quick_br($sformatf("cmp%0d_%0d", i, j), codes[i], 1'b0,
                         32'h0000_2000 + 32'(i * 16 + j * 4), 16'h0008,
                         rsv[j], 32'd0);
            end
        end
        chk("cmp.br_cnt", 32'(bus.br_cnt), 32'd12);
        chk("cmp.taken_cnt", 32'(bus.taken_cnt), 32'd6);

        // Flush while waiting on rs
        drive_br(3'd1, 1'b0, 32'h0000_3000, 16'h0002, 32'd7, 32'd7);
        bus.rs_rdy = 1'b0;
        #1;
        chk("flush.stall0", {31'd0, bus.stall_o}, 32'd1);
        exp_st = sat(exp_st + 1);
        step();
        bus.valid_d = 1'b0;
        bus.flush_i = 1'b1;
        #1;
        chk("flush.stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        bus.flush_i = 1'b0;
        bus.rs_rdy  = 1'b1;
        chk("flush.idle", {31'd0, bus.in_slot_o}, 32'd0);
        chk("flush.redirect0", {31'd0, bus.redirect_o}, 32'd0);
        #1;
        chk("flush.no_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        chk("flush.redirect1", {31'd0, bus.redirect_o}, 32'd0);
        chk("flush.link_we", {31'd0, bus.link_we_o}, 32'd0);
        chk_cnt("flush");
        idle_in();

        // Stall counter saturation
        drive_br(3'd3, 1'b0, 32'h0000_4000, 16'h0000, 32'd1, 32'd0);
        bus.rs_rdy = 1'b0;
        for (int k = 0; k < 70; k++) begin
            exp_st = sat(exp_st + 1);
            step();
        end
        chk("sat.stall_cnt", 32'(bus.stall_cnt), 32'(MAXC));
        bus.valid_d = 1'b0;
        bus.flush_i = 1'b1;
        step();
        idle_in();

        // Branch/taken counter saturation
        for (int k = 0; k < 66; k++) begin
            quick_br("sat_br", 3'd1, 1'b0, 32'h0000_5000, 16'h0001,
                     32'd9, 32'd9);
        end
        chk("sat.br_cnt", 32'(bus.br_cnt), 32'(MAXC));
        chk("sat.taken_cnt", 32'(bus.taken_cnt), 32'(MAXC));
        chk_cnt("sat");

        // Clear wins over a simultaneous resolution
        drive_br(3'd1, 1'b0, 32'h0000_6000, 16'h0003, 32'd4, 32'd4);
        bus.cnt_clr = 1'b1;
        push_exp(3'd1, 1'b0, 32'h0000_6000, 16'h0003, 32'd4, 32'd4);
        exp_br = 0;
        exp_tk = 0;
        exp_st = 0;
        step();
        bus.cnt_clr = 1'b0;
        check_res("clrwin");
        chk_cnt("clrwin");
        slot_leave("clrwin");

        // Asynchronous reset while in the delay slot
        drive_br(3'd5, 1'b1, 32'h0000_7000, 16'h0004, 32'd3, 32'd0);
        push_exp(3'd5, 1'b1, 32'h0000_7000, 16'h0004, 32'd3, 32'd0);
        step();
        check_res("arst_pre");
        idle_in();
        #2;
        rst = 1'b1;
        #1;
        exp_br = 0;
        exp_tk = 0;
        exp_st = 0;
        chk("arst.in_slot", {31'd0, bus.in_slot_o}, 32'd0);
        chk("arst.redirect", {31'd0, bus.redirect_o}, 32'd0);
        chk("arst.link_we", {31'd0, bus.link_we_o}, 32'd0);
        chk("arst.target", bus.target_o, 32'd0);
        chk("arst.link_pc", bus.link_pc_o, 32'd0);
        chk_cnt("arst");
        step();
        rst = 1'b0;
        step();
        chk("arst.idle", {31'd0, bus.in_slot_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch resolution in the decode stage of the 5-stage MIPS core.
- Consumes the decoded 3-bit branch code plus rs/rt operands and their forwarding-ready flags.
- Stalls fetch/decode until the operands are ready, resolves the condition, and issues a one-cycle PC redirect.
- Tracks the delay slot and keeps saturating branch performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset: asynchronous, active-high
- stall_i  in  1  global pipeline hold; decode contents frozen
- flush_i  in  1  exception flush; highest priority
- valid_d  in  1  decode slot holds a valid instruction
- branchcontrol_d  in  3  branch code from defines.vh: 000 none, 001 BRANCH_EQ, 010 BRANCH_NEQ, 011 BRANCH_GTZ, 100 BRANCH_LEZ, 101 BRANCH_GEZ, 110 BRANCH_LTZ, 111 reserved (treated as none)
- link_d  in  1  instruction is an -AL variant
- pc_d  in  32  PC of the decode instruction
- imm_d  in  16  branch offset field
- rs_val, rt_val  in  32 each  forwarded operands
- rs_rdy, rt_rdy  in  1 each  operand valid; low while a load result is pending
- cnt_clr  in  1  synchronous clear of all counters
- stall_o  out  1  combinational; hold PC and IF/ID
- redirect_o  out  1  registered one-cycle pulse; fetch loads target_o
- target_o  out  32  registered branch target
- link_we_o  out  1  registered pulse; write link_pc_o to $31
- link_pc_o  out  32  registered; pc + 8
- in_slot_o  out  1  state==SLOT
- br_cnt, taken_cnt, stall_cnt  out  CNT_W each  perf counters

Behaviour:
- Reset: all outputs and counters 0; state IDLE; latched pc/imm/code/link 0.
- States: IDLE, WAIT, SLOT.
- need_rt = code is EQ or NEQ.
- ready = rs_rdy & (rt_rdy | ~need_rt).
- accept (IDLE only) = valid_d & code in 001..110 & ~stall_i & ~flush_i.
- IDLE, accept & ready: resolve this cycle.
  - Next cycle: redirect_o = taken; target_o = pc_d + 4 + (sext(imm_d) << 2), mod 2^32.
  - link_we_o = link_d, regardless of taken; link_pc_o = pc_d + 8.
  - Next state SLOT.
- IDLE, accept & ~ready: stall_o = 1; latch code/pc/imm/link; next state WAIT.
- WAIT: stall_o = ~ready, evaluated with the latched code and live rs/rt.
  - When ready & ~stall_i: resolve with latched fields (same output timing as IDLE); next state SLOT.
  - stall_i holds WAIT.
- Conditions on rs, signed:
  - EQ: rs == rt; NEQ: rs != rt.
  - GTZ: rs > 0; LEZ: rs <= 0; GEZ: rs >= 0; LTZ: rs < 0.
- SLOT: in_slot_o = 1. Branch codes here are ignored (delay-slot branch not supported). Leaves to IDLE on valid_d & ~stall_i.
- redirect_o and link_we_o are single-cycle pulses; never high two cycles in a row.
- flush_i, any state: next state IDLE; stall_o = 0 that cycle; any resolution that cycle is suppressed. A redirect pulse already registered still drops next cycle.
- Counters, each saturating at all-ones:
  - br_cnt +1 per resolution; taken_cnt +1 per taken resolution.
  - stall_cnt +1 per cycle with stall_o = 1.
  - cnt_clr wins over increment.
- Reset asserted mid-WAIT or mid-SLOT: immediate return to IDLE, outputs 0, asynchronously.

Test Plan:
- BEQ, pc_d=0x00400000, imm=0x0004, rs=rt=5, both ready → stall_o=0; next cycle redirect_o=1, target_o=0x00400014, in_slot_o=1; after one valid_d, state IDLE.
- BNE with rt_rdy=0 for 2 cycles → stall_o=1 for 2 cycles, stall_cnt=2; redirect one cycle after rt_rdy rises, using latched pc.
- BLTZAL, rs=0xFFFFFFFF, imm=0xFFFF, pc=0x1000 → taken, target_o=0x1000, link_we_o=1, link_pc_o=0x1008. Same with rs=0 → redirect_o=0, link_we_o=1.
- GTZ/LEZ/GEZ/LTZ with rs in {0x80000000, 0, 1} → signed outcomes; br_cnt=12, taken_cnt=6.
- flush_i during WAIT → IDLE next cycle, no redirect, stall_o=0 that cycle. Counter preload near all-ones then branches → holds all-ones; cnt_clr → 0.
